sysarr_ps_buffer: RTL and testbench
===================================

Name: sysarr_ps_buffer

Overview:
- Parametrised partial-sum buffer placed between the systolic array output edge and the result write-back path.
- Accepts whole rows of N partial sums through a valid/ready handshake and holds up to DEPTH rows in a circular store.
- Drains either one element per beat (serial mode) or one full row per beat (row mode), also through a valid/ready handshake.
- Has a synchronous flush and occupancy/status reporting.

Parameters:
- N, 4: elements per row (array columns).
- WIDTH, 16: bits per partial-sum element.
- DEPTH, 2: row slots in the buffer; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of all buffered content.
- in_valid  input  1  in_row holds a valid row.
- in_ready  output  1  buffer can accept a row this cycle.
- in_row  input  N*WIDTH  row to store; element k is in_row[k*WIDTH +: WIDTH].
- row_mode  input  1  drain mode: 0 = serial element drain, 1 = whole-row drain.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  N*WIDTH  row mode: head row; serial mode: current element in [WIDTH-1:0], upper bits 0.
- out_last  output  1  beat completes the head row.
- out_col  output  $clog2(N) (min 1)  index of the element currently presented in serial mode; 0 in row mode.
- count  output  $clog2(DEPTH+1)  number of rows stored, including a partially drained head row.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- State: DEPTH×N×WIDTH storage, wr_ptr, rd_ptr (0..DEPTH-1, wrap to 0 after DEPTH-1), count, col (0..N-1), mode_q.
- Reset (rst high, async):
  - pointers, count, col and mode_q all 0; storage cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, out_col=0, count=0, full=0, empty=1.
  - Reset mid-drain discards everything.
- in_ready = !full (combinational from registered state). No write-through while full, even if a row pop happens the same cycle.
- Push: in_valid && in_ready → in_row written to slot wr_ptr; wr_ptr advances.
- Push latency: a row pushed into an empty buffer appears on out_valid/out_data the next cycle. No same-cycle bypass.
- out_valid = !empty. When empty, out_data=0, out_last=0 and out_col=0.
- Effective mode = row_mode when col==0, else mode_q. mode_q captures row_mode on every cycle with col==0.
- A mode change while a serial row is partially drained takes effect only after that row completes.
- Serial mode:
  - out_data[WIDTH-1:0] = head element col.
  - On a beat (out_valid && out_ready), col increments.
  - out_last = (col==N-1). A beat with out_last pops the row: rd_ptr advances and col returns to 0.
  - Elements drain in order 0..N-1.
- Row mode:
  - out_data = full head row; out_last=1 on every valid beat.
  - A beat pops the row.
- Simultaneous push and row pop in the same cycle: count unchanged, both pointers advance.
- A serial beat that does not complete the row leaves count unchanged.
- out_valid && !out_ready: out_data, out_col and out_last hold stable. Stalls are unlimited.
- flush:
  - Next state: pointers=0, count=0, col=0.
  - Overrides any push or pop in the same cycle; that in_row is dropped.
  - Storage contents need not be cleared.
- count never exceeds DEPTH and never underflows; a pop is only possible when out_valid=1.
- Arithmetic is none; values pass through bit-exact.

Test Plan:
- Defaults for all scenarios: N=4, WIDTH=16, DEPTH=2.
- Reset then idle:
  - Required: in_ready=1, empty=1, out_valid=0, out_data=0, count=0.
  - Assert rst asynchronously mid-cycle with count=2 → outputs return to reset values before the next edge.
- Serial drain, row_mode=0, out_ready=1:
  - Push row {0x0004,0x0003,0x0002,0x0001} (element0=0x0001).
  - Required: out_data[15:0]=0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles starting the cycle after the push.
  - Required: out_col 0..3 and out_last only on 0x0004. count is 1 throughout, then 0.
- Full/backpressure:
  - Push rows A and B with out_ready=0 → count=2, full=1, in_ready=0.
  - A third in_valid row C is not accepted.
  - Raise out_ready in row mode → A then B delivered, out_last=1 on each beat. After the first pop, in_ready=1.
- Simultaneous push and pop at count=1 in row mode:
  - Required: count stays 1, the pointers wrap correctly over 6 iterations, and rows emerge in push order.
- Mode change mid-row:
  - Serial drain of row 0x4444_3333_2222_1111 with row_mode flipped to 1 after 2 beats.
  - Required: elements 0x3333 and 0x4444 still emitted serially, then the next row comes out as a whole-row beat.
- Flush with count=2, col=2, and in_valid asserted in the same cycle:
  - Required: next cycle count=0, empty=1, out_valid=0, out_col=0, and the pushed row is dropped.
  - A subsequent push is delivered correctly from slot 0.

Source files
------------

// File: rtl/sysarr_ps_buffer.sv
// sysarr_ps_buffer
// Partial-sum row buffer between the systolic array output edge and the
// result write-back path. Whole rows of N elements are accepted through a
// valid/ready handshake into a circular store of DEPTH slots and drained
// either one element per beat (serial mode) or one full row per beat (row
// mode).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of all buffered rows
//   in_valid/ready  row input handshake, in_row carries N elements
//   row_mode        0 = serial element drain, 1 = whole-row drain
//   out_valid/ready output beat handshake
//   out_data        head row (row mode) or current element in the low WIDTH bits
//   out_last        beat completes the head row
//   out_col         element index presented in serial mode, 0 otherwise
//   count/full/empty occupancy, a partially drained head row still counts
module sysarr_ps_buffer #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CW   = (N > 1) ? $clog2(N) : 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW   = $clog2(DEPTH + 1),
  localparam int DW   = N * WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_row,
  input  logic          row_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] out_col,
  output logic [NW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] LAST_COL  = CW'(N - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [NW-1:0] DEPTH_CNT = NW'(DEPTH);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [NW-1:0]    count_r;
  logic [CW-1:0]    col_r;
  logic             mode_q_r;

  logic             full_s;
  logic             empty_s;
  logic             eff_mode_s;
  logic             push_s;
  logic             beat_s;
  logic             pop_s;
  logic [DW-1:0]    head_row_s;
  logic [WIDTH-1:0] elem_s [N];

  assign head_row_s = mem_r[rd_ptr_r];

  for (genvar k = 0; k < N; k++) begin : g_elem
    assign elem_s[k] = head_row_s[k*WIDTH +: WIDTH];
  end

  // Handshake decode; the drain mode may only change on a row boundary.
  always_comb begin
    full_s  = (count_r == DEPTH_CNT);
    empty_s = (count_r == {NW{1'b0}});
    if (col_r == {CW{1'b0}}) begin
      eff_mode_s = row_mode;
    end else begin
      eff_mode_s = mode_q_r;
    end
    // Acceptance looks only at registered fullness: no write-through on a pop.
    push_s = in_valid && !full_s;
    beat_s = !empty_s && out_ready;
    pop_s  = beat_s && (eff_mode_s || (col_r == LAST_COL));
  end

  // Output decode from the registered head row and column.
  always_comb begin
    out_data = {DW{1'b0}};
    out_last = 1'b0;
    out_col  = {CW{1'b0}};
    if (empty_s) begin
      out_data = {DW{1'b0}};
    end else if (eff_mode_s) begin
      out_data = head_row_s;
      out_last = 1'b1;
    end else begin
      out_data[WIDTH-1:0] = elem_s[col_r];
      out_last            = (col_r == LAST_COL);
      out_col             = col_r;
    end
  end

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign count     = count_r;
  assign full      = full_s;
  assign empty     = empty_s;

  // Row storage; a flush drops the row offered in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= in_row;
    end
  end

  // Pointers, occupancy and serial column tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
      col_r    <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
      col_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_SLOT) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_SLOT) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + NW'(1);
        2'b01:   count_r <= count_r - NW'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s) begin
        col_r <= {CW{1'b0}};
      end else if (beat_s) begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Latch the requested mode at every row boundary so it holds mid-row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q_r <= 1'b0;
    end else if (col_r == {CW{1'b0}}) begin
      mode_q_r <= row_mode;
    end
  end

endmodule

// File: tb/tb_sysarr_ps_buffer.sv
module tb_sysarr_ps_buffer;
  localparam int N = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int DW = N * WIDTH;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_row;
  logic          row_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_col;
  logic [1:0]    count;
  logic          full;
  logic          empty;

  sysarr_ps_buffer #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .row_mode(row_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_col(out_col),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of rows plus the index of the next element of
  // the head row and the mode remembered for a partially drained row.
  logic [DW-1:0] mq[$];
  int            idx;
  bit            mlatch;

  logic [DW-1:0] beat_log[$];
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model update on each clock edge (or reset)
  initial begin
    bit was_empty;
    bit was_full;
    bit eff;
    idx = 0;
    mlatch = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        idx = 0;
        mlatch = 1'b0;
      end else begin
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        eff = (idx == 0) ? row_mode : mlatch;
        if (idx == 0) mlatch = row_mode;
        if (flush) begin
          mq.delete();
          idx = 0;
        end else begin
          if (!was_empty && out_ready) begin
            if (eff) begin
              void'(mq.pop_front());
              idx = 0;
            end else begin
              idx++;
              if (idx == N) begin
                void'(mq.pop_front());
                idx = 0;
              end
            end
          end
          if (in_valid && !was_full) mq.push_back(in_row);
        end
      end
    end
  end

  // Monitor: compare every visible output against the model mid-cycle
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          el;
    int            ec;
    bit            eff;
    if (!rst) begin
      ed = '0;
      el = 1'b0;
      ec = 0;
      if (mq.size() != 0) begin
        eff = (idx == 0) ? row_mode : mlatch;
        if (eff) begin
          ed = mq[0];
          el = 1'b1;
        end else begin
          ed = (mq[0] >> (idx * WIDTH)) & 64'h0000_0000_0000_FFFF;
          el = (idx == N - 1);
          ec = idx;
        end
      end
      check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("count",     64'(count),     64'(mq.size()));
      check("full",      64'(full),      64'(mq.size() == DEPTH));
      check("empty",     64'(empty),     64'(mq.size() == 0));
      check("out_data",  out_data,       ed);
      check("out_last",  64'(out_last),  64'(el));
      check("out_col",   64'(out_col),   64'(ec));
      if (out_valid && out_ready) beat_log.push_back(out_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [DW-1:0] r);
    in_valid = 1'b1;
    in_row = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic log_check(input string name, input int k, input logic [DW-1:0] exp);
    if (k < beat_log.size()) check(name, beat_log[k], exp);
    else check(name, 'x, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_row = '0;
    row_mode = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_empty",     64'(empty),     64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_count",     64'(count),     64'd0);
    tick();

    // Serial drain
    row_mode = 1'b0;
    out_ready = 1'b1;
    beat_log.delete();
    push_row(64'h0004_0003_0002_0001);
    repeat (5) tick();
    check("ser_nbeats", 64'(beat_log.size()), 64'd4);
    log_check("ser_b0", 0, 64'h0001);
    log_check("ser_b1", 1, 64'h0002);
    log_check("ser_b2", 2, 64'h0003);
    log_check("ser_b3", 3, 64'h0004);

    // Full / backpressure
    out_ready = 1'b0;
    push_row(64'hAAAA_AAAA_AAAA_0001);
    push_row(64'hBBBB_BBBB_BBBB_0002);
    check("bp_count",    64'(count),    64'd2);
    check("bp_full",     64'(full),     64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    push_row(64'hCCCC_CCCC_CCCC_0003);
    row_mode = 1'b1;
    out_ready = 1'b1;
    beat_log.delete();
    repeat (3) tick();
    check("bp_nbeats", 64'(beat_log.size()), 64'd2);
    log_check("bp_a", 0, 64'hAAAA_AAAA_AAAA_0001);
    log_check("bp_b", 1, 64'hBBBB_BBBB_BBBB_0002);

    // Simultaneous push and pop in row mode
    beat_log.delete();
    in_valid = 1'b1;
    in_row = 64'h1000_0000_0000_0000;
    tick();
    for (int i = 1; i <= 6; i++) begin
      in_row = 64'h1000_0000_0000_0000 + 64'(i);
      tick();
      check("pp_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("pp_nbeats", 64'(beat_log.size()), 64'd7);
    for (int i = 0; i < 7; i++) log_check("pp_order", i, 64'h1000_0000_0000_0000 + 64'(i));

    // Mode change mid-row
    row_mode = 1'b0;
    out_ready = 1'b0;
    push_row(64'h4444_3333_2222_1111);
    push_row(64'h8888_7777_6666_5555);
    beat_log.delete();
    out_ready = 1'b1;
    repeat (2) tick();
    row_mode = 1'b1;
    repeat (4) tick();
    check("mc_nbeats", 64'(beat_log.size()), 64'd5);
    log_check("mc_b2", 2, 64'h3333);
    log_check("mc_b3", 3, 64'h4444);
    log_check("mc_row", 4, 64'h8888_7777_6666_5555);

    // Flush with count=2, col=2 and a push offered
    row_mode = 1'b0;
    out_ready = 1'b0;
    push_row(64'h0D0D_0C0C_0B0B_0A0A);
    push_row(64'h1D1D_1C1C_1B1B_1A1A);
    out_ready = 1'b1;
    repeat (2) tick();
    check("fl_col_before", 64'(out_col), 64'd2);
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    in_row = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_count",     64'(count),     64'd0);
    check("fl_empty",     64'(empty),     64'd1);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_col",   64'(out_col),   64'd0);
    repeat (2) tick();
    check("fl_dropped", 64'(out_valid), 64'd0);
    beat_log.delete();
    out_ready = 1'b1;
    row_mode = 1'b1;
    push_row(64'h5A5A_0000_1234_5678);
    repeat (2) tick();
    check("fl_nbeats", 64'(beat_log.size()), 64'd1);
    log_check("fl_after", 0, 64'h5A5A_0000_1234_5678);

    // Asynchronous reset mid-cycle with two rows stored
    out_ready = 1'b0;
    push_row(64'h0000_0000_0000_00A1);
    push_row(64'h0000_0000_0000_00B2);
    check("ar_count_pre", 64'(count), 64'd2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("ar_count",     64'(count),     64'd0);
    check("ar_empty",     64'(empty),     64'd1);
    check("ar_in_ready",  64'(in_ready),  64'd1);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_data",  out_data,       64'd0);
    check("ar_full",      64'(full),      64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = (($urandom % 4) != 0);
      row_mode  = 1'($urandom_range(0, 1));
      flush     = (($urandom % 40) == 0);
      in_row    = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    check("end_empty", 64'(empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
